// File: rtl/psram_arb_pkg.sv
// Shared types and constants for the two-port PSRAM arbiter.
// State encoding, port IDs and timeout default.
package psram_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_ACK
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int BUSY_TIMEOUT_DEF = 4;

endpackage

// File: rtl/psram_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the port not granted last wins.
// Purely combinational; the caller owns the last-grant register.
module rr_pick2
  import psram_arb_pkg::*;
(
  input  logic a_req_i,
  input  logic b_req_i,
  input  logic last_i,
  output logic grant_o,
  output logic valid_o
);

  always_comb begin
    valid_o = a_req_i | b_req_i;
    grant_o = PORT_A;
    if (a_req_i && b_req_i)
      grant_o = (last_i == PORT_A) ? PORT_B : PORT_A;
    else if (b_req_i)
      grant_o = PORT_B;
  end

endmodule

// File: rtl/psram_arbiter.sv
// Shares one PsramController between ports A and B, one byte
// command per request, following the controller busy handshake.
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 22,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [7:0]            a_wdata,
  output logic                  a_ack,
  output logic [7:0]            a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [7:0]            b_wdata,
  output logic                  b_ack,
  output logic [7:0]            b_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_byte_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_din,
  input  logic [15:0]           mem_dout,
  input  logic                  mem_busy,
  output logic                  timeout_err
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  state_t state_q, state_d;
  logic            last_q, last_d;
  logic            gnt_q, gnt_d;
  logic            we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]     din_q, din_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [7:0]      rda_q, rda_d;
  logic [7:0]      rdb_q, rdb_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic            acka_q, acka_d;
  logic            ackb_q, ackb_d;

  logic pick_gnt, pick_vld;
  logic grant, tmo_hit, cap;
  logic [7:0] rsel;

  rr_pick2 u_pick (
    .a_req_i (a_req),
    .b_req_i (b_req),
    .last_i  (last_q),
    .grant_o (pick_gnt),
    .valid_o (pick_vld)
  );

  // Busy gating in IDLE also drains power-up init and reset leftovers
  assign grant   = (state_q == S_IDLE) && pick_vld && !mem_busy;
  assign tmo_hit = (cnt_q == CW'(BUSY_TIMEOUT - 1));
  assign cap     = (state_q == S_WAIT_LO) && !mem_busy && !we_q;
  assign rsel    = addr_q[0] ? mem_dout[15:8] : mem_dout[7:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= PORT_B;
      gnt_q   <= PORT_A;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rda_q   <= '0;
      rdb_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      acka_q  <= 1'b0;
      ackb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rda_q   <= rda_d;
      rdb_q   <= rdb_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      acka_q  <= acka_d;
      ackb_q  <= ackb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (grant) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT_HI;
      S_WAIT_HI: begin
        if (mem_busy)     state_d = S_WAIT_LO;
        else if (tmo_hit) state_d = S_ACK;
      end
      S_WAIT_LO: if (!mem_busy) state_d = S_ACK;
      S_ACK:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    last_d = last_q;
    gnt_d  = gnt_q;
    we_d   = we_q;
    addr_d = addr_q;
    din_d  = din_q;
    if (grant) begin
      last_d = pick_gnt;
      gnt_d  = pick_gnt;
      we_d   = (pick_gnt == PORT_B) ? b_we : a_we;
      addr_d = (pick_gnt == PORT_B) ? b_addr : a_addr;
      din_d  = (pick_gnt == PORT_B) ? {b_wdata, b_wdata}
                                    : {a_wdata, a_wdata};
    end
    cnt_d = cnt_q;
    if (state_q == S_ISSUE)
      cnt_d = '0;
    else if (state_q == S_WAIT_HI)
      cnt_d = cnt_q + 1'b1;
    err_d = err_q;
    if (state_q == S_WAIT_HI && !mem_busy && tmo_hit)
      err_d = 1'b1;
    rda_d = (cap && gnt_q == PORT_A) ? rsel : rda_q;
    rdb_d = (cap && gnt_q == PORT_B) ? rsel : rdb_q;
    rd_d   = (state_d == S_ISSUE) && !we_d;
    wr_d   = (state_d == S_ISSUE) && we_d;
    acka_d = (state_d == S_ACK) && (gnt_d == PORT_A);
    ackb_d = (state_d == S_ACK) && (gnt_d == PORT_B);
  end

  assign mem_read       = rd_q;
  assign mem_write      = wr_q;
  assign mem_byte_write = wr_q;
  assign mem_addr       = addr_q;
  assign mem_din        = din_q;
  assign a_ack          = acka_q;
  assign b_ack          = ackb_q;
  assign a_rdata        = rda_q;
  assign b_rdata        = rdb_q;
  assign timeout_err    = err_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Scoreboard bench for psram_arbiter with a behavioural
// PsramController busy model.
module tb_psram_arbiter;

  localparam int AW = 22;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [7:0]    a_wdata = '0, b_wdata = '0;
  logic          a_ack, b_ack;
  logic [7:0]    a_rdata, b_rdata;
  logic          mem_read, mem_write, mem_byte_write;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic [15:0]   mem_dout = 16'hBEEF;
  logic          mem_busy;
  logic          timeout_err;

  logic model_busy = 0, force_busy = 0, no_busy = 0;
  int   busy_len = 3;
  assign mem_busy = model_busy | force_busy;

  psram_arbiter #(.ADDR_WIDTH(AW), .BUSY_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_write(mem_byte_write), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_busy(mem_busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [15:0]   din;
  } cmd_t;
  typedef struct {
    logic       port;
    logic [7:0] rdata;
  } ack_t;

  cmd_t cmd_q[$];
  ack_t ack_q[$];
  int checks = 0, fails = 0;
  int cyc = 0, nstrobe = 0, strobe_cyc = 0, ack_cyc = 0;
  logic [7:0] exp_rd [2] = '{8'h00, 8'h00};

  always @(posedge clock) cyc <= cyc + 1;

  // Controller model: busy rises the cycle after a strobe
  always begin
    @(posedge clock);
    if ((mem_read || mem_write) && !no_busy) begin
      #1 model_busy = 1'b1;
      repeat (busy_len) @(posedge clock);
      #1 model_busy = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_cmd(input logic we, input logic [AW-1:0] ad,
                          input logic [7:0] wd);
    cmd_t c;
    c.we = we;
    c.addr = ad;
    c.din = {wd, wd};
    cmd_q.push_back(c);
  endtask

  task automatic expect_txn(input logic p, input logic we,
                            input logic [AW-1:0] ad,
                            input logic [7:0] wd, input logic tmo);
    ack_t a;
    push_cmd(we, ad, wd);
    if (!we && !tmo)
      exp_rd[p] = ad[0] ? mem_dout[15:8] : mem_dout[7:0];
    a.port = p;
    a.rdata = exp_rd[p];
    ack_q.push_back(a);
  endtask

  always @(negedge clock) begin
    cmd_t c;
    ack_t a;
    if (mem_read && mem_write) begin
      fails++;
      $display("FAIL strobe_overlap: read=1 write=1 required one-hot");
    end
    if (mem_read || mem_write) begin
      nstrobe++;
      strobe_cyc = cyc;
      if (cmd_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_cmd: addr %0h none expected", mem_addr);
      end else begin
        c = cmd_q.pop_front();
        chk("cmd_read", 32'(mem_read), 32'(!c.we));
        chk("cmd_write", 32'(mem_write), 32'(c.we));
        chk("cmd_bytewr", 32'(mem_byte_write), 32'(c.we));
        chk("cmd_addr", 32'(mem_addr), 32'(c.addr));
        if (c.we) chk("cmd_din", 32'(mem_din), 32'(c.din));
      end
    end
    if (a_ack && b_ack) begin
      fails++;
      $display("FAIL ack_overlap: both acks high required one");
    end
    if (a_ack || b_ack) begin
      ack_cyc = cyc;
      if (ack_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack: a=%0d b=%0d none expected",
                 a_ack, b_ack);
      end else begin
        a = ack_q.pop_front();
        chk("ack_port", 32'(b_ack), 32'(a.port));
        chk("ack_rdata", 32'(a.port ? b_rdata : a_rdata), 32'(a.rdata));
      end
    end
  end

  task automatic do_req(input logic p, input logic we,
                        input logic [AW-1:0] ad, input logic [7:0] wd);
    logic got;
    got = 1'b0;
    if (p) begin
      b_we = we; b_addr = ad; b_wdata = wd; b_req = 1'b1;
    end else begin
      a_we = we; a_addr = ad; a_wdata = wd; a_req = 1'b1;
    end
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clock);
      #1 got = p ? b_ack : a_ack;
    end
    if (p) b_req = 1'b0;
    else   a_req = 1'b0;
    chk("ack_seen", 32'(got), 32'd1);
    @(negedge clock);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0, k;
    logic seen;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_read", 32'(mem_read), 0);
    chk("rst_write", 32'(mem_write), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_din", 32'(mem_din), 0);
    chk("rst_acks", 32'({a_ack, b_ack}), 0);
    chk("rst_rdata", 32'({a_rdata, b_rdata}), 0);
    chk("rst_err", 32'(timeout_err), 0);
    @(negedge clock);
    reset = 1'b0;

    // A reads 0x11, busy high 3 cycles
    mem_dout = 16'hBEEF;
    busy_len = 3;
    expect_txn(1'b0, 1'b0, 22'h000011, 8'h00, 1'b0);
    do_req(1'b0, 1'b0, 22'h000011, 8'h00);
    chk("t1_a_rdata", 32'(a_rdata), 32'h0000_00BE);

    // B byte write at top address, minimum latency
    busy_len = 1;
    expect_txn(1'b1, 1'b1, 22'h3FFFFE, 8'h5A, 1'b0);
    do_req(1'b1, 1'b1, 22'h3FFFFE, 8'h5A);
    chk("t2_latency", 32'(ack_cyc - strobe_cyc), 32'd3);
    chk("t2_b_rdata", 32'(b_rdata), 32'd0);

    // Both ports busy: grants alternate starting with A
    mem_dout = 16'hC33C;
    busy_len = 2;
    expect_txn(1'b0, 1'b0, 22'h000101, 8'h00, 1'b0);
    expect_txn(1'b1, 1'b1, 22'h3F0000, 8'hA5, 1'b0);
    expect_txn(1'b0, 1'b0, 22'h000200, 8'h00, 1'b0);
    expect_txn(1'b1, 1'b0, 22'h000007, 8'h00, 1'b0);
    expect_txn(1'b0, 1'b1, 22'h000300, 8'h11, 1'b0);
    expect_txn(1'b1, 1'b0, 22'h000008, 8'h00, 1'b0);
    fork
      begin
        do_req(1'b0, 1'b0, 22'h000101, 8'h00);
        do_req(1'b0, 1'b0, 22'h000200, 8'h00);
        do_req(1'b0, 1'b1, 22'h000300, 8'h11);
      end
      begin
        do_req(1'b1, 1'b1, 22'h3F0000, 8'hA5);
        do_req(1'b1, 1'b0, 22'h000007, 8'h00);
        do_req(1'b1, 1'b0, 22'h000008, 8'h00);
      end
    join
    chk("t3_a_rdata", 32'(a_rdata), 32'h3C);
    chk("t3_b_rdata", 32'(b_rdata), 32'h3C);

    // Controller init holds busy after reset
    @(negedge clock);
    reset = 1'b1;
    force_busy = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    chk("t4_rdata_cleared", 32'(a_rdata), 0);
    n0 = nstrobe;
    busy_len = 3;
    expect_txn(1'b0, 1'b0, 22'h000022, 8'h00, 1'b0);
    fork
      do_req(1'b0, 1'b0, 22'h000022, 8'h00);
      begin
        repeat (20) @(posedge clock);
        #1 chk("t4_no_strobe_busy", 32'(nstrobe - n0), 0);
        force_busy = 1'b0;
      end
    join
    chk("t4_a_rdata", 32'(a_rdata), 32'h3C);

    // Busy never rises: timeout after four WAIT_HI cycles
    no_busy = 1'b1;
    expect_txn(1'b0, 1'b0, 22'h000033, 8'h00, 1'b1);
    fork
      do_req(1'b0, 1'b0, 22'h000033, 8'h00);
      begin
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clock);
          seen = mem_read;
        end
        k = 0;
        for (int i = 0; i < 20 && !timeout_err; i++) begin
          @(negedge clock);
          k++;
        end
        chk("t5_tmo_delay", 32'(k), 32'd5);
      end
    join
    chk("t5_err", 32'(timeout_err), 32'd1);
    chk("t5_a_rdata", 32'(a_rdata), 32'h3C);
    no_busy = 1'b0;

    // Reset while waiting for busy to fall
    busy_len = 8;
    push_cmd(1'b0, 22'h000044, 8'h00);
    a_we = 1'b0; a_addr = 22'h000044; a_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      seen = mem_read;
    end
    chk("t6_strobe_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    a_req = 1'b0;
    @(posedge clock);
    #1;
    chk("t6_rst_strobes", 32'({mem_read, mem_write}), 0);
    chk("t6_rst_ack", 32'({a_ack, b_ack}), 0);
    chk("t6_rst_err", 32'(timeout_err), 0);
    chk("t6_busy_draining", 32'(mem_busy), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    n0 = nstrobe;
    busy_len = 2;
    expect_txn(1'b1, 1'b1, 22'h000055, 8'h77, 1'b0);
    fork
      do_req(1'b1, 1'b1, 22'h000055, 8'h77);
      begin
        for (int i = 0; i < 50 && mem_busy; i++) @(negedge clock);
        #1 chk("t6_wait_drain", 32'(nstrobe - n0), 0);
      end
    join

    repeat (4) @(negedge clock);
    chk("cmd_q_empty", 32'(cmd_q.size()), 0);
    chk("ack_q_empty", 32'(ack_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
